// File: rtl/video_pixel_unpacker.sv
// Streaming pixel unpacker: takes packed DMA words and emits one pixel per clock
// at 1/2/4/8/16 bpp, with per-line first-pixel skip and pixel repeat.
module video_pixel_unpacker #(
   parameter  int WORD_W = 32,
   localparam int IDX_W  = $clog2(WORD_W)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [2:0]        cfg_bpp,
   input  logic [1:0]        cfg_rep,
   input  logic              line_start,
   input  logic [IDX_W-1:0]  line_skip,
   input  logic [WORD_W-1:0] in_word,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [15:0]       pix_out,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic              pix_first
);

   logic [WORD_W-1:0] hold;
   logic              have;
   logic              skip_pending;
   logic              first_pending;
   logic [IDX_W-1:0]  idx;
   logic [IDX_W-1:0]  skip_q;
   logic [IDX_W-1:0]  last_idx;
   logic [IDX_W-1:0]  sh;
   logic [1:0]        rep_cnt;
   logic [1:0]        rep_q;
   logic [2:0]        bpp_q;
   logic [2:0]        bpp_new;
   logic [15:0]       pix_mask;
   logic [15:0]       pix_next;
   logic              adv;
   logic              rep_done;
   logic              last;
   logic              accept;

   // Index of the last pixel in a word for a given log2(bpp); doubles as the skip mask.
   function automatic logic [IDX_W-1:0] top_idx(input logic [2:0] b);
      return IDX_W'((WORD_W >> b) - 1);
   endfunction

   assign bpp_new  = (cfg_bpp > 3'd4) ? 3'd4 : cfg_bpp;
   assign last_idx = top_idx(bpp_q);
   assign sh       = idx << bpp_q;

   always_comb begin
      case (bpp_q)
         3'd0:    pix_mask = 16'h0001;
         3'd1:    pix_mask = 16'h0003;
         3'd2:    pix_mask = 16'h000F;
         3'd3:    pix_mask = 16'h00FF;
         default: pix_mask = 16'hFFFF;
      endcase
   end

   assign pix_next = 16'(hold >> sh) & pix_mask;
   assign rep_done = (rep_cnt == rep_q);
   assign adv      = have && (!pix_valid || pix_ready) && !line_start;
   assign last     = adv && rep_done && (idx == last_idx);
   // Next word is taken in the cycle the last pixel leaves, so there is no bubble between words.
   assign in_ready = (!have || last) && !line_start && !reset;
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold          <= '0;
         have          <= 1'b0;
         idx           <= '0;
         rep_cnt       <= '0;
         bpp_q         <= '0;
         rep_q         <= '0;
         skip_pending  <= 1'b0;
         skip_q        <= '0;
         first_pending <= 1'b0;
         pix_out       <= '0;
         pix_valid     <= 1'b0;
         pix_first     <= 1'b0;
      end else if (line_start) begin
         have          <= 1'b0;
         pix_valid     <= 1'b0;
         pix_first     <= 1'b0;
         idx           <= '0;
         rep_cnt       <= '0;
         bpp_q         <= bpp_new;
         rep_q         <= cfg_rep;
         skip_pending  <= 1'b1;
         skip_q        <= line_skip & top_idx(bpp_new);
         first_pending <= 1'b1;
      end else begin
         if (adv) begin
            pix_out       <= pix_next;
            pix_valid     <= 1'b1;
            pix_first     <= first_pending;
            first_pending <= 1'b0;
            if (rep_done) begin
               rep_cnt <= '0;
               idx     <= idx + 1'b1;
            end else begin
               rep_cnt <= rep_cnt + 1'b1;
            end
            if (last) begin
               have <= 1'b0;
               idx  <= '0;
            end
         end else if (!have && pix_ready) begin
            pix_valid <= 1'b0;
            pix_first <= 1'b0;
         end
         if (accept) begin
            hold <= in_word;
            have <= 1'b1;
            if (skip_pending) begin
               idx          <= skip_q;
               skip_pending <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_video_pixel_unpacker.sv
// Scoreboard bench for video_pixel_unpacker: directed scenarios plus randomized lines.
module tb_video_pixel_unpacker;
   localparam int WORD_W = 32;
   localparam int IDX_W  = $clog2(WORD_W);

   logic              clk = 1'b0;
   logic              reset;
   logic [2:0]        cfg_bpp;
   logic [1:0]        cfg_rep;
   logic              line_start;
   logic [IDX_W-1:0]  line_skip;
   logic [WORD_W-1:0] in_word;
   logic              in_valid;
   logic              in_ready;
   logic [15:0]       pix_out;
   logic              pix_valid;
   logic              pix_ready;
   logic              pix_first;

   video_pixel_unpacker #(.WORD_W(WORD_W)) dut (
      .clk(clk), .reset(reset), .cfg_bpp(cfg_bpp), .cfg_rep(cfg_rep),
      .line_start(line_start), .line_skip(line_skip), .in_word(in_word),
      .in_valid(in_valid), .in_ready(in_ready), .pix_out(pix_out),
      .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_first(pix_first)
   );

   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [16:0] exp_q[$];
   int          m_bpp, m_rep, m_skip;
   bit          m_first_word, m_first_pix;
   int          hs_count = 0;
   int          rdy_mode = 0;
   logic [15:0] prev_pix;
   logic        prev_first;
   bit          prev_stall = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: each accepted word expands to its pixel list from the line's rules.
   task automatic model_push(input logic [WORD_W-1:0] w);
      int          ppw;
      int          bits;
      int          start;
      logic [63:0] mask;
      logic [15:0] v;
      ppw   = WORD_W >> m_bpp;
      bits  = 1 << m_bpp;
      start = m_first_word ? (m_skip % ppw) : 0;
      mask  = (64'd1 << bits) - 64'd1;
      m_first_word = 0;
      for (int i = start; i < ppw; i++) begin
         v = 16'((64'(w) >> (i * bits)) & mask);
         for (int r = 0; r <= m_rep; r++) begin
            exp_q.push_back({m_first_pix, v});
            m_first_pix = 0;
         end
      end
   endtask

   initial begin : monitor
      logic [16:0] e;
      forever begin
         @(negedge clk);
         if (reset) begin
            exp_q.delete();
            m_bpp = 0; m_rep = 0; m_skip = 0;
            m_first_word = 0; m_first_pix = 0;
            prev_stall = 0;
         end else begin
            if (prev_stall) begin
               check("stall_valid", 32'(pix_valid), 32'd1);
               check("stall_pix", 32'(pix_out), 32'(prev_pix));
               check("stall_first", 32'(pix_first), 32'(prev_first));
            end
            prev_stall = pix_valid && !pix_ready && !line_start;
            prev_pix   = pix_out;
            prev_first = pix_first;
            if (pix_valid && pix_ready) begin
               hs_count++;
               if (exp_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_pix: got 0x%0h expected no pixel at %0t", pix_out, $time);
               end else begin
                  e = exp_q.pop_front();
                  check("pix", 32'(pix_out), 32'(e[15:0]));
                  check("first", 32'(pix_first), 32'(e[16]));
               end
            end
            if (line_start) begin
               exp_q.delete();
               m_bpp  = (cfg_bpp > 3'd4) ? 4 : int'(cfg_bpp);
               m_rep  = int'(cfg_rep);
               m_skip = int'(line_skip);
               m_first_word = 1;
               m_first_pix  = 1;
            end else if (in_valid && in_ready) begin
               model_push(in_word);
            end
         end
      end
   end

   initial begin : ready_gen
      int ph = 0;
      forever begin
         @(posedge clk);
         #1;
         if (rdy_mode == 1) pix_ready = ($urandom_range(0, 2) != 0);
         else if (rdy_mode == 2) begin
            pix_ready = (ph % 4 == 0) || (ph % 4 == 3);
            ph++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called at posedge+1; a junk word is offered alongside line_start and must be refused.
   task automatic do_line(input int b, input int r, input int s);
      cfg_bpp    = 3'(b);
      cfg_rep    = 2'(r);
      line_skip  = IDX_W'(s);
      line_start = 1'b1;
      in_word    = $urandom;
      in_valid   = 1'b1;
      #1 check("in_ready_ls", 32'(in_ready), 32'd0);
      tick();
      line_start = 1'b0;
      in_valid   = 1'b0;
      cfg_bpp    = 3'($urandom);
      cfg_rep    = 2'($urandom);
      line_skip  = IDX_W'($urandom);
   endtask

   task automatic send_word(input logic [WORD_W-1:0] w);
      int n = 0;
      in_word  = w;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("drain", 32'(exp_q.size()), 32'd0);
      tick();
   endtask

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation did not finish at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int base;
      int k;
      int run;
      reset = 1'b1; cfg_bpp = '0; cfg_rep = '0; line_start = 1'b0; line_skip = '0;
      in_word = '0; in_valid = 1'b0; pix_ready = 1'b1;
      repeat (3) tick();
      check("rst_pix_out", 32'(pix_out), 32'd0);
      check("rst_pix_valid", 32'(pix_valid), 32'd0);
      check("rst_pix_first", 32'(pix_first), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      reset = 1'b0;
      tick();

      // 8 bpp bytes in order
      do_line(3, 0, 0);
      send_word(32'h44332211);
      drain();

      // 1 bpp doubled, two words back-to-back at full rate
      do_line(0, 1, 0);
      pix_ready = 1'b1;
      run = 0;
      k   = 0;
      fork
         begin
            send_word(32'h00000005);
            send_word(32'h55555555);
         end
         begin
            @(negedge clk);
            while (!pix_valid && k < 20) begin
               @(negedge clk);
               k++;
            end
            for (int i = 0; i < 128; i++) begin
               if (pix_valid && pix_ready) run++;
               @(negedge clk);
            end
         end
      join
      check("throughput", 32'(run), 32'd128);
      drain();

      // 4 bpp with skip of 5, next word follows
      do_line(2, 0, 5);
      send_word(32'h87654321);
      send_word(32'hFEDCBA90);
      drain();

      // 16 bpp with scripted backpressure
      rdy_mode = 2;
      do_line(4, 0, 0);
      send_word(32'hBBBBAAAA);
      send_word(32'hDDDDCCCC);
      drain();
      rdy_mode  = 0;
      pix_ready = 1'b1;

      // line_start part-way through a word
      do_line(3, 0, 0);
      base = hs_count;
      send_word(32'h44332211);
      k = 0;
      while (hs_count < base + 2 && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("mid_line_hs", 32'(hs_count >= base + 2), 32'd1);
      tick();
      do_line(3, 0, 0);
      send_word(32'h0000FFEE);
      drain();

      // asynchronous reset mid-line
      rdy_mode = 1;
      do_line(1, 2, 3);
      send_word($urandom);
      repeat (5) tick();
      #2 reset = 1'b1;
      #1;
      check("arst_pix_out", 32'(pix_out), 32'd0);
      check("arst_pix_valid", 32'(pix_valid), 32'd0);
      check("arst_pix_first", 32'(pix_first), 32'd0);
      check("arst_in_ready", 32'(in_ready), 32'd0);
      tick();
      reset     = 1'b0;
      rdy_mode  = 0;
      pix_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("post_rst_idle", 32'(pix_valid), 32'd0);
      end
      tick();
      send_word($urandom);
      drain();

      // randomized lines
      repeat (25) begin
         rdy_mode = $urandom_range(0, 1);
         if (rdy_mode == 0) pix_ready = 1'b1;
         do_line($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 31));
         repeat ($urandom_range(1, 3)) begin
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 4)) tick();
            send_word($urandom);
         end
         if ($urandom_range(0, 3) != 0) drain();
      end
      rdy_mode  = 0;
      pix_ready = 1'b1;
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/video_pixel_unpacker.md
Name: video_pixel_unpacker

Overview:
Streaming pixel unpacker between the video DMA word FIFO and the palette/colour lookup stage. It replaces per-X-index combinational pixel selection with a self-sequencing engine. The engine accepts packed words over a valid/ready handshake and emits one pixel per clock at 1/2/4/8/16 bpp. It adds a parametrised word width, a per-line first-pixel skip for fine horizontal scroll, and pixel repeat for horizontal doubling.

Parameters:
WORD_W, 32, DMA word width in bits; power of two, 32..128.
IDX_W, $clog2(WORD_W), width of the pixel index within a word (derived; do not override).

Ports:
clk  in  1  system/pixel clock
reset  in  1  asynchronous, active-high reset
cfg_bpp  in  3  log2(bpp): 0=1,1=2,2=4,3=8,4=16; values 5..7 treated as 4; sampled only at line_start
cfg_rep  in  2  pixel repeat count minus 1 (0..3 => each pixel output 1..4 times); sampled at line_start
line_start  in  1  single-cycle pulse: flush, latch cfg, arm skip
line_skip  in  IDX_W  pixels to discard from first word of the line; sampled at line_start
in_word  in  WORD_W  packed pixels, pixel 0 in LSBs
in_valid  in  1  in_word valid
in_ready  out  1  word accepted when in_valid && in_ready
pix_out  out  16  pixel value, zero-extended to 16 bits
pix_valid  out  1  pix_out valid
pix_ready  in  1  downstream accepts pixel when pix_valid && pix_ready
pix_first  out  1  high with the first pixel emitted after line_start

Behaviour:
- Reset (async): pix_out=0, pix_valid=0, pix_first=0, in_ready=0, holding register empty, idx=0, rep_cnt=0, bpp_q=0, rep_q=0, skip_pending=0.
- State: holding register hold[WORD_W-1:0] + have flag; idx (IDX_W); rep_cnt (2b); latched bpp_q, rep_q.
- ppw = WORD_W >> bpp_q. Pixel extract: (hold >> (idx << bpp_q)) masked to 2^bpp_q bits. Zero-extend to 16 bits.
- Advance condition: adv = have && (!pix_valid || pix_ready).
- On adv: pix_out <= extracted pixel; pix_valid <= 1. If rep_cnt==rep_q, then rep_cnt<=0 and idx<=idx+1. Otherwise rep_cnt<=rep_cnt+1 and idx is held.
- Last-pixel condition: last = adv && rep_cnt==rep_q && idx==ppw-1. On last: have<=0 and idx<=0 (index wraps).
- Output draining: if !have and pix_ready, then pix_valid <= 0.
- in_ready (combinational): (!have || last) && !line_start. There is no bubble between words: the word accepted in the last-pixel cycle is loaded (have=1) and used on the next clock.
- Throughput: 1 pixel/clk sustained while words arrive back-to-back and pix_ready=1. Latency: 1 clk from word acceptance to first pixel registering on pix_out.
- Backpressure: pix_ready=0 with pix_valid=1 freezes pix_out, idx, rep_cnt and hold. In that case in_ready=0 unless have=0.
- line_start (takes priority over everything in that cycle):
  - have<=0, pix_valid<=0, idx<=0, rep_cnt<=0.
  - bpp_q<=clamped cfg_bpp; rep_q<=cfg_rep.
  - skip_pending<=1; skip_q <= line_skip masked to log2(ppw) bits, using the new bpp (i.e. line_skip mod ppw).
- Skip load: the first word accepted while skip_pending loads idx<=skip_q, then clears skip_pending. The skipped pixels are never output. The next pixel emitted has pix_first=1; pix_first=0 otherwise. pix_first follows pix_out under backpressure.
- line_start mid-word or mid-repeat: the remaining pixels of the current word are discarded. A pixel held on pix_out is also dropped (pix_valid falls the next cycle regardless of pix_ready).
- A word offered in the line_start cycle is not accepted.
- cfg_* changes between line_start pulses have no effect.
- 16 bpp with WORD_W=32: ppw=2. 1 bpp with WORD_W=128: ppw=128, so the full 7-bit idx is used.

Test Plan:
- Reset, then line_start with bpp=3, rep=0, skip=0; word 0x44332211, pix_ready=1 -> pix_out 0x11,0x22,0x33,0x44 on consecutive clocks. pix_first=1 only with 0x11; in_ready=0 during line_start.
- bpp=0, rep=1, skip=0; word 0x00000005 -> pix_out 1,1,0,0,1,1,0,0,... for 64 cycles. Word accepted in the last-pixel cycle, then a second word follows with no gap.
- bpp=2, skip=5; word 0x87654321 -> first pix_out 0x6 (pix_first=1), then 0x7, 0x8. The next word's nibble 0 follows immediately.
- bpp=4, pix_ready toggled 1,0,0,1 with words 0xBBBBAAAA, 0xDDDDCCCC -> output sequence 0xAAAA, 0xBBBB, 0xCCCC, 0xDDDD. Each value is held stable while pix_ready=0; none are lost or duplicated.
- line_start asserted after 2 of 4 8-bpp pixels, then new word 0x0000FFEE, bpp=3 -> the old word's remaining pixels never appear. Next output is 0xEE with pix_first=1.
- Assert reset asynchronously mid-line -> all outputs 0 immediately, without waiting for a clk edge. No pixel output until a new word is accepted.
